isqrt_seq: RTL
==============

# isqrt_seq

Iterative integer square-root responder: accepts a single-cycle request on the `x_vld`/`x` side and returns `floor(sqrt(x))` on the `y_vld`/`y` side. It is the responder end of the isqrt interface that the formula FSMs drive as initiators. The formula FSMs instantiate it once per isqrt port. It uses one digit-by-digit (2 bits per cycle) iteration unit, trading throughput for area against a pipelined isqrt.

## Interface
- `WIDTH`, default 32: radicand width. Must be even and ≥ 2. Result width is `WIDTH/2`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; one clock, asynchronous assertion, active-low.
- `x_vld`  input  1  request strobe, single cycle; no hold required from initiator.
- `x`  input  WIDTH  radicand, sampled only when the request is accepted.
- `y_vld`  output  1  result strobe, exactly one cycle per accepted request.
- `y`  output  WIDTH/2  result; holds the last result between strobes.
- `busy`  output  1  high while iterating; requests are not accepted.
- `overrun`  output  1  sticky; set when `x_vld` arrives while `busy`. Cleared only by reset.

## Operation
- State machine with states `st_idle`, `st_calc`, `st_done`. The state register and all outputs are registered.
- `st_idle`: when `x_vld`=1, load the request and go to `st_calc`. Loading sets:
  - `rad` = `x`
  - `rem` = 0
  - `root` = 0
  - `cnt` = 0
- `st_calc`: one iteration per cycle.
  - `rem' = (rem << 2) | rad[WIDTH-1:WIDTH-2]`
  - `trial = (root << 2) | 1`
  - If `rem' >= trial`: `rem = rem' - trial`, `root = (root << 1) | 1`.
  - Otherwise: `rem = rem'`, `root = root << 1`.
  - Then `rad <<= 2` and `cnt++`.
  - After iteration `WIDTH/2 - 1` (the last one), go to `st_done`.
- `st_done`: `y_vld`=1 and `y`=`root`.
  - If `x_vld`=1 in this cycle, accept it (load as in `st_idle`) and go to `st_calc`.
  - Otherwise go to `st_idle`.
- Width rules:
  - `rem` is `WIDTH/2 + 2` bits. It never overflows; no truncation anywhere.
  - `root` is `WIDTH/2` bits.
  - `cnt` is `$clog2(WIDTH/2)` bits.
- Request while in `st_calc`:
  - Ignored; no state or datapath change.
  - `overrun` is set on the next edge.
  - The in-flight result is unaffected.
- No backpressure on `y`: the initiator must capture the result in the `y_vld` cycle.
- Reset values: `y_vld`=0, `y`=0, `busy`=0, `overrun`=0, state `st_idle`.
- Reset during `st_calc` or `st_done` aborts the operation. No `y_vld` is produced for it.

## Timing
- Accepted request at cycle T (`x_vld` sampled on the edge ending T):
  - `busy`=1 in cycles T+1 … T+WIDTH/2.
  - `y_vld`=1 in cycle T+WIDTH/2+1.
- Latency is `WIDTH/2 + 1` cycles: 17 for `WIDTH`=32.
- Request acceptance:
  - Accepted in any `st_idle` or `st_done` cycle.
  - Back-to-back throughput: one result per `WIDTH/2 + 1` cycles.
  - A request in the `y_vld` cycle produces its result at +17 with no gap.
- `y` changes only on the edge entering `st_done`.
- Simultaneous `x_vld` and `y_vld` in `st_done`: the result is delivered and the new request is accepted. `overrun` is not set.

## Structure
- Shared package `isqrt_pkg`:
  - State enum typedef `isqrt_state_t` (2-bit).
  - Helper function `isqrt_lat(width)` returning `width/2 + 1`. The formula FSMs and benches use it for timeouts.
- Sub-module `isqrt_step`: purely combinational single iteration.
  - Inputs: `rem`, `root`, top 2 radicand bits.
  - Outputs: next `rem`, next `root`.
  - Parameterised by `WIDTH`.
  - Reused by a future pipelined isqrt.

## Test plan
- Requests x=0, 1, 15 (one at a time, idle between): `y` = 0, 1, 3 respectively, each with `y_vld` exactly 17 cycles after its `x_vld`.
- x=16, x=0xFFFF_FFFF, x=0xFFFE_0001: `y` = 4, 0xFFFF, 0xFFFF; `busy` high for exactly 16 cycles each.
- x=100, then x=81 asserted in the `y_vld` cycle of the first: `y`=10 at T+17 and `y`=9 at T+34. `overrun` stays 0.
- x=49 at T, extra `x_vld` with x=4 at T+5: `y`=7 at T+17, no second `y_vld`, `overrun`=1 from T+6 and held.
- x=1_000_000 at T, `rst_n` low at T+8 for 1 cycle:
  - All outputs 0 immediately after reset.
  - No `y_vld` for the aborted request.
  - A new request x=144 returns 12.
- 10,000 random x including corners (0, 2^k, 2^k−1, squares, squares−1), random idle gaps: every `y` equals `floor(sqrt(x))` and `y_vld` count equals accepted-request count.

Source files
------------

// File: rtl/isqrt_pkg.sv
// rtl/isqrt_pkg.sv - shared types and helpers for the iterative isqrt responder
package isqrt_pkg;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_calc = 2'd1,
      st_done = 2'd2
   } isqrt_state_t;

   // Request-to-result latency in cycles for a given radicand width.
   function automatic int isqrt_lat(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one combinational digit-by-digit square-root iteration
module isqrt_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH/2+1:0] rem_i,
   input  logic [WIDTH/2-1:0] root_i,
   input  logic [1:0]         bits_i,
   output logic [WIDTH/2+1:0] rem_o,
   output logic [WIDTH/2-1:0] root_o
);

   localparam int HW = WIDTH / 2;
   localparam int RW = HW + 2;

   logic [RW-1:0] rem_sh;
   logic [RW-1:0] trial;
   logic          take;

   // Bring down the next radicand digit pair and try subtracting 4*root+1.
   always_comb begin
      rem_sh = (rem_i << 2) | {{(RW-2){1'b0}}, bits_i};
      trial  = {root_i, 2'b01};
      take   = (rem_sh >= trial);
      rem_o  = take ? (rem_sh - trial) : rem_sh;
      root_o = (root_i << 1) | HW'(take);
   end

endmodule

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - iterative integer square root, two radicand bits per cycle
module isqrt_seq
   import isqrt_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               x_vld,
   input  logic [WIDTH-1:0]   x,
   output logic               y_vld,
   output logic [WIDTH/2-1:0] y,
   output logic               busy,
   output logic               overrun
);

   localparam int HW = WIDTH / 2;
   localparam int RW = HW + 2;
   localparam int CW = (HW > 1) ? $clog2(HW) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HW - 1);

   isqrt_state_t  state_q;
   logic [WIDTH-1:0] rad_q;
   logic [RW-1:0] rem_q;
   logic [RW-1:0] rem_d;
   logic [HW-1:0] root_q;
   logic [HW-1:0] root_d;
   logic [CW-1:0] cnt_q;
   logic [HW-1:0] y_q;
   logic          y_vld_q;
   logic          busy_q;
   logic          overrun_q;

   isqrt_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (rem_q),
      .root_i (root_q),
      .bits_i (rad_q[WIDTH-1 -: 2]),
      .rem_o  (rem_d),
      .root_o (root_d)
   );

   // Control FSM and datapath registers; result strobe lasts one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= st_idle;
         rad_q     <= '0;
         rem_q     <= '0;
         root_q    <= '0;
         cnt_q     <= '0;
         y_q       <= '0;
         y_vld_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         y_vld_q <= 1'b0;
         case (state_q)
            st_idle, st_done: begin
               if (x_vld) begin
                  rad_q   <= x;
                  rem_q   <= '0;
                  root_q  <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= st_calc;
               end else begin
                  state_q <= st_idle;
               end
            end
            st_calc: begin
               rem_q  <= rem_d;
               root_q <= root_d;
               rad_q  <= rad_q << 2;
               cnt_q  <= cnt_q + CW'(1);
               // A request while iterating is dropped but remembered.
               if (x_vld) begin
                  overrun_q <= 1'b1;
               end
               if (cnt_q == CNT_LAST) begin
                  y_q     <= root_d;
                  y_vld_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= st_done;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= st_idle;
            end
         endcase
      end
   end

   assign y_vld   = y_vld_q;
   assign y       = y_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule
